// File: rtl/vga_timing_pkg.sv
// Mode constants and shared types for the VGA raster timing path.
// Default mode is 800x480@60 (CVT) on a 29.5 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 72;
  localparam int unsigned DEF_H_BP     = 96;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 7;
  localparam int unsigned DEF_V_BP     = 10;
  localparam bit          DEF_HS_POL   = 1'b0;
  localparam bit          DEF_VS_POL   = 1'b1;
  localparam int unsigned DEF_CNT_W    = 11;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Full description of one video mode, kept together so modes can be switched as a unit.
  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } timing_mode_t;

  localparam timing_mode_t MODE_800X480_60 = '{
    h_active: 16'(DEF_H_ACTIVE),
    h_fp:     16'(DEF_H_FP),
    h_sync:   16'(DEF_H_SYNC),
    h_bp:     16'(DEF_H_BP),
    v_active: 16'(DEF_V_ACTIVE),
    v_fp:     16'(DEF_V_FP),
    v_sync:   16'(DEF_V_SYNC),
    v_bp:     16'(DEF_V_BP),
    hs_pol:   DEF_HS_POL,
    vs_pol:   DEF_VS_POL
  };

  function automatic int unsigned mode_h_total(timing_mode_t m);
    return 32'(m.h_active) + 32'(m.h_fp) + 32'(m.h_sync) + 32'(m.h_bp);
  endfunction

  function automatic int unsigned mode_v_total(timing_mode_t m);
    return 32'(m.v_active) + 32'(m.v_fp) + 32'(m.v_sync) + 32'(m.v_bp);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single-bit level crossing into the clk_i domain.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters gated by the synchronised PLL lock, followed by a
// register stage producing sync, display-enable, pixel coordinates and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = DEF_HS_POL,
  parameter bit          VS_POL   = DEF_VS_POL,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             lock_sync;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             hs_active, vs_active;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_sync)
  );

  // Counters sit at the origin until lock is seen, so timing always restarts at a frame boundary.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!lock_sync) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_ONE;
    end else begin
      h_cnt_d = h_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    de_d          = lock_sync && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_active     = lock_sync && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vs_active     = lock_sync && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    hsync_d       = hs_active ? HS_POL : ~HS_POL;
    vsync_d       = vs_active ? VS_POL : ~VS_POL;
    pix_x_d       = de_d ? h_cnt_q : '0;
    pix_y_d       = de_d ? v_cnt_q : '0;
    line_start_d  = de_d && (h_cnt_q == '0);
    frame_start_d = line_start_d && (v_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = lock_sync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance and a reduced-mode instance share stimulus
// and are checked every cycle against a raster-position model, plus vector and corner sequences.
module tb_vga_timing_gen;

  localparam int unsigned CW = 11;

  // Reduced mode so whole frames stay short; polarities inverted relative to the default mode.
  localparam int unsigned S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int unsigned S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 2;
  localparam bit          S_HPOL = 1'b1, S_VPOL = 1'b0;
  localparam int unsigned S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int unsigned S_VT = S_VA + S_VFP + S_VS + S_VBP;
  localparam int unsigned S_FRAME = S_HT * S_VT;

  typedef struct {
    int unsigned ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit          hpol, vpol;
  } mode_t;

  typedef struct packed {
    logic          hs, vs, de, ls, fs, run;
    logic [CW-1:0] x, y;
  } obs_t;

  typedef struct {
    bit          rst;
    bit          lock;
    int unsigned adv;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, pll_locked;
  always #5 clk = ~clk;

  logic          d_hs, d_vs, d_de, d_ls, d_fs, d_run;
  logic [CW-1:0] d_x, d_y;
  logic          s_hs, s_vs, s_de, s_ls, s_fs, s_run;
  logic [CW-1:0] s_x, s_y;

  vga_timing_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .de          (d_de),
    .pix_x       (d_x),
    .pix_y       (d_y),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .running     (d_run)
  );

  vga_timing_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
    .HS_POL   (S_HPOL), .VS_POL (S_VPOL), .CNT_W (CW)
  ) u_dut_small (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .de          (s_de),
    .pix_x       (s_x),
    .pix_y       (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .running     (s_run)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  mode_t dm, sm;
  obs_t  last_d, last_s;
  int unsigned d_max_x = 0, d_max_y = 0, s_max_x = 0, s_max_y = 0;

  // Model state: lock as sampled on the previous edge, synchronised lock, and cycles since lock.
  bit          samp1 = 1'b0;
  bit          m_run = 1'b0;
  int unsigned m_age = 0;

  function automatic obs_t mk(bit hs, bit vs, bit de, bit ls, bit fs, bit run, int unsigned x,
                              int unsigned y);
    obs_t o;
    o.hs = hs; o.vs = vs; o.de = de; o.ls = ls; o.fs = fs; o.run = run;
    o.x = CW'(x); o.y = CW'(y);
    return o;
  endfunction

  // Expected registered outputs given lock state and elapsed running cycles before the edge.
  function automatic obs_t model_out(mode_t m, bit run, int unsigned age);
    int unsigned ht, vt, pos, h, v;
    bit de, hs_on, vs_on;
    ht    = m.ha + m.hfp + m.hs + m.hbp;
    vt    = m.va + m.vfp + m.vs + m.vbp;
    pos   = age % (ht * vt);
    h     = pos % ht;
    v     = pos / ht;
    de    = run && (h < m.ha) && (v < m.va);
    hs_on = run && (h >= m.ha + m.hfp) && (h < m.ha + m.hfp + m.hs);
    vs_on = run && (v >= m.va + m.vfp) && (v < m.va + m.vfp + m.vs);
    return mk(hs_on ? m.hpol : !m.hpol, vs_on ? m.vpol : !m.vpol, de, de && h == 0,
              de && h == 0 && v == 0, 1'b0, de ? h : 0, de ? v : 0);
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("hs=%b vs=%b de=%b ls=%b fs=%b run=%b x=%0d y=%0d",
                     o.hs, o.vs, o.de, o.ls, o.fs, o.run, o.x, o.y);
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got [%s] required [%s]", name, $time, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare both instances.
  task automatic tick();
    obs_t ed, es;
    @(posedge clk);
    if (rst) begin
      samp1 = 1'b0;
      m_run = 1'b0;
      m_age = 0;
      ed = model_out(dm, 1'b0, 0);
      es = model_out(sm, 1'b0, 0);
    end else begin
      ed = model_out(dm, m_run, m_age);
      es = model_out(sm, m_run, m_age);
      m_age = m_run ? m_age + 1 : 0;
      m_run = samp1;
      samp1 = pll_locked;
    end
    ed.run = m_run;
    es.run = m_run;
    #1;
    last_d = mk(d_hs, d_vs, d_de, d_ls, d_fs, d_run, 32'(d_x), 32'(d_y));
    last_s = mk(s_hs, s_vs, s_de, s_ls, s_fs, s_run, 32'(s_x), 32'(s_y));
    check_obs("model_default", last_d, ed);
    check_obs("model_small", last_s, es);
    if (32'(d_x) > d_max_x) d_max_x = 32'(d_x);
    if (32'(d_y) > d_max_y) d_max_y = 32'(d_y);
    if (32'(s_x) > s_max_x) s_max_x = 32'(s_x);
    if (32'(s_y) > s_max_y) s_max_y = 32'(s_y);
  endtask

  // Advance until the small instance shows an active pixel at (x, y); give up after a bound.
  task automatic wait_small_at(string name, int unsigned x, int unsigned y);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3 * S_FRAME && !seen; k++) begin
      tick();
      seen = last_s.de && (32'(last_s.x) == x) && (32'(last_s.y) == y);
    end
    check_int(name, int'(seen), 1);
  endtask

  task automatic ticks_to_small_fs(output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (last_s.fs) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    vec_t vecs[14];
    int   n, period, vs_cnt, ls_cnt, de_cnt;
    bit   seen;

    dm = '{ha: 800, hfp: 24, hs: 72, hbp: 96, va: 480, vfp: 3, vs: 7, vbp: 10,
           hpol: 1'b0, vpol: 1'b1};
    sm = '{ha: S_HA, hfp: S_HFP, hs: S_HS, hbp: S_HBP, va: S_VA, vfp: S_VFP, vs: S_VS,
           vbp: S_VBP, hpol: S_HPOL, vpol: S_VPOL};

    // Default mode: output k edges after edge 3 reflects h=k of line 0.
    vecs[0]  = '{rst: 1, lock: 1, adv: 3,  exp: mk(1, 0, 0, 0, 0, 0, 0,   0)};
    vecs[1]  = '{rst: 0, lock: 1, adv: 1,  exp: mk(1, 0, 0, 0, 0, 0, 0,   0)};
    vecs[2]  = '{rst: 0, lock: 1, adv: 1,  exp: mk(1, 0, 0, 0, 0, 1, 0,   0)};
    vecs[3]  = '{rst: 0, lock: 1, adv: 1,  exp: mk(1, 0, 1, 1, 1, 1, 0,   0)};
    vecs[4]  = '{rst: 0, lock: 1, adv: 1,  exp: mk(1, 0, 1, 0, 0, 1, 1,   0)};
    vecs[5]  = '{rst: 0, lock: 1, adv: 798, exp: mk(1, 0, 1, 0, 0, 1, 799, 0)};
    vecs[6]  = '{rst: 0, lock: 1, adv: 1,  exp: mk(1, 0, 0, 0, 0, 1, 0,   0)};
    vecs[7]  = '{rst: 0, lock: 1, adv: 23, exp: mk(1, 0, 0, 0, 0, 1, 0,   0)};
    vecs[8]  = '{rst: 0, lock: 1, adv: 1,  exp: mk(0, 0, 0, 0, 0, 1, 0,   0)};
    vecs[9]  = '{rst: 0, lock: 1, adv: 71, exp: mk(0, 0, 0, 0, 0, 1, 0,   0)};
    vecs[10] = '{rst: 0, lock: 1, adv: 1,  exp: mk(1, 0, 0, 0, 0, 1, 0,   0)};
    vecs[11] = '{rst: 0, lock: 1, adv: 95, exp: mk(1, 0, 0, 0, 0, 1, 0,   0)};
    vecs[12] = '{rst: 0, lock: 1, adv: 1,  exp: mk(1, 0, 1, 1, 0, 1, 0,   1)};
    vecs[13] = '{rst: 0, lock: 1, adv: 799, exp: mk(1, 0, 1, 0, 0, 1, 799, 1)};

    rst = 1'b1;
    pll_locked = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst;
      pll_locked = vecs[i].lock;
      for (int k = 0; k < int'(vecs[i].adv); k++) tick();
      check_obs($sformatf("vec%0d", i), last_d, vecs[i].exp);
    end

    // Whole frame on the reduced instance: period, vsync width, strobe and enable counts.
    seen = 1'b0;
    for (int k = 0; k < 2 * S_FRAME && !seen; k++) begin
      tick();
      seen = last_s.fs;
    end
    check_int("small_fs_seen", int'(seen), 1);
    period = 0; vs_cnt = 0; ls_cnt = 0; de_cnt = 0;
    for (int k = 1; k <= 2 * S_FRAME; k++) begin
      tick();
      if (last_s.vs == S_VPOL) vs_cnt++;
      if (last_s.ls) ls_cnt++;
      if (last_s.de) de_cnt++;
      if (last_s.fs) begin
        period = k;
        break;
      end
    end
    check_int("frame_period", period, S_FRAME);
    check_int("vsync_width", vs_cnt, S_VS * S_HT);
    check_int("line_starts", ls_cnt, S_VA);
    check_int("de_cycles", de_cnt, S_HA * S_VA);

    // Lock loss mid-frame, then re-lock.
    wait_small_at("reach_lock_drop_point", 8, 3);
    pll_locked = 1'b0;
    tick(); tick(); tick();
    check_obs("lock_drop_small", last_s, mk(!S_HPOL, !S_VPOL, 0, 0, 0, 0, 0, 0));
    check_obs("lock_drop_default", last_d, mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) tick();
    pll_locked = 1'b1;
    ticks_to_small_fs(n);
    check_int("relock_fs_latency", n, 3);
    check_obs("relock_small", last_s, mk(!S_HPOL, !S_VPOL, 1, 1, 1, 1, 0, 0));

    // One-cycle reset mid-frame with lock held.
    wait_small_at("reach_reset_point", 2, 5);
    rst = 1'b1;
    tick();
    check_obs("rst_small", last_s, mk(!S_HPOL, !S_VPOL, 0, 0, 0, 0, 0, 0));
    check_obs("rst_default", last_d, mk(1, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    ticks_to_small_fs(n);
    check_int("rst_fs_latency", n, 3);
    check_int("rst_default_fs", int'(last_d.fs), 1);

    // Random lock glitches and occasional resets against the model.
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 99) < 2) pll_locked = ~pll_locked;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    check_int("default_max_x", int'(d_max_x), 799);
    check_int("default_max_y_in_range", int'(d_max_y <= 479), 1);
    check_int("small_max_x", int'(s_max_x), S_HA - 1);
    check_int("small_max_y", int'(s_max_y), S_VA - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
